// File: rtl/pr_timer_pkg.sv
// Shared register map, CTRL field positions and FSM encodings for pr_timer.
// Optional STATUS register is enabled by defining TIMER_IRQ_STATUS_EN.
package pr_timer_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IM = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } timerState_t;

    // MODE=1x behaves as one-shot, so only the exact 01 code reloads
    function automatic logic isReload(input logic [3:0] ctrl);
        return ctrl[2:1] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/be_merge.sv
// Byte-enable merge of a new word over an old word; purely combinational.
// Shared with the bridge and data memory write paths.
module be_merge (
    input  logic [31:0] oldWord,
    input  logic [31:0] newWord,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        merged = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = newWord[8*i +: 8];
        end
    end

endmodule

// File: rtl/pr_timer.sv
// Memory-mapped down-counting timer with level interrupt on the Pr* bus.
// Define TIMER_IRQ_STATUS_EN to expose the pending flag at offset 3 (write 1 to clear).
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | stopped, waiting for CTRL.EN
//   S_LOAD | COUNT <= PRESET
//   S_CNT  | decrementing; EN=0 stops and holds COUNT
//   S_INT  | set pending; reload (MODE=01) or clear EN and stop
module pr_timer
    import pr_timer_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000,
    parameter int          CNT_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    timerState_t      state, stateNext;
    logic [3:0]       ctrl, ctrlNext;
    logic [CNT_W-1:0] preset, presetNext;
    logic [CNT_W-1:0] count, countNext;
    logic             pending, pendingNext;
    logic             firstCnt;

    logic [31:0] regWord;
    logic [31:0] merged;
    logic        wrCtrl, wrPreset, autoClr;
    logic        unusedBits;

    always_comb begin
        regWord = '0;
        case (addr[3:2])
            TMR_CTRL:   regWord = {28'b0, ctrl};
            TMR_PRESET: regWord = 32'(preset);
            TMR_COUNT:  regWord = 32'(count);
            TMR_STATUS: begin
`ifdef TIMER_IRQ_STATUS_EN
                regWord = {31'b0, pending};
`else
                regWord = '0;
`endif
            end
            default:    regWord = '0;
        endcase
    end

    assign rd  = sel ? regWord : 32'b0;
    assign irq = pending & ctrl[CTRL_IM];

    be_merge uMerge (
        .oldWord (regWord),
        .newWord (wd),
        .be      (be),
        .merged  (merged)
    );

    assign wrCtrl   = sel && we && (addr[3:2] == TMR_CTRL);
    assign wrPreset = sel && we && (addr[3:2] == TMR_PRESET);
    // firstCnt marks the cycle right after LOAD, stretching the reload pulse to two cycles
    assign autoClr  = (state == S_CNT) && firstCnt && isReload(ctrl);

`ifdef TIMER_IRQ_STATUS_EN
    logic wrStatusClr;
    assign wrStatusClr = sel && we && (addr[3:2] == TMR_STATUS) && be[0] && wd[0];
`endif

    always_comb begin
        stateNext   = state;
        countNext   = count;
        ctrlNext    = ctrl;
        presetNext  = preset;
        pendingNext = pending;

        case (state)
            S_IDLE: begin
                if (ctrl[CTRL_EN]) stateNext = S_LOAD;
            end
            S_LOAD: begin
                countNext = preset;
                stateNext = S_CNT;
            end
            S_CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    stateNext = S_IDLE;
                end else if (count > CNT_W'(1)) begin
                    countNext = count - CNT_W'(1);
                end else begin
                    countNext = '0;
                    stateNext = S_INT;
                end
            end
            S_INT: begin
                if (isReload(ctrl)) begin
                    stateNext = S_LOAD;
                end else begin
                    ctrlNext[CTRL_EN] = 1'b0;
                    stateNext         = S_IDLE;
                end
            end
            default: stateNext = S_IDLE;
        endcase

        if (autoClr) pendingNext = 1'b0;

        // bus write overrides the FSM's own EN clear
        if (wrCtrl) begin
            ctrlNext    = merged[3:0];
            pendingNext = 1'b0;
        end
        if (wrPreset) presetNext = merged[CNT_W-1:0];

`ifdef TIMER_IRQ_STATUS_EN
        if (wrStatusClr) pendingNext = 1'b0;
`endif

        // a set in the same edge as any clear wins
        if (state == S_INT) pendingNext = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ctrl     <= '0;
            preset   <= PRESET_RST[CNT_W-1:0];
            count    <= '0;
            pending  <= 1'b0;
            firstCnt <= 1'b0;
        end else begin
            state    <= stateNext;
            ctrl     <= ctrlNext;
            preset   <= presetNext;
            count    <= countNext;
            pending  <= pendingNext;
            firstCnt <= (state == S_LOAD);
        end
    end

    assign unusedBits = ^{addr[31:4], addr[1:0], merged};

endmodule

// File: tb/tb_pr_timer.sv
// Directed testbench for pr_timer: table-driven register access plus timing sequences.
module tb_pr_timer;

    localparam logic [31:0] RST_PRESET = 32'h0000_00C3;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    pr_timer #(.PRESET_RST(RST_PRESET), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] expRd;
        logic        expIrq;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; be = b; wd = d;
        tick();
        sel = 1'b0; we = 1'b0; be = 4'h0; wd = 32'h0;
    endtask

    task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        check(name, rd, exp);
        sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] expCnt;
        logic        expIrq;

        //            sel   we    addr   be     wd            expRd         expIrq
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 4'h0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h4, 4'h0, 32'h0,        RST_PRESET,   1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h8, 4'h0, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'hC, 4'h0, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h4, 4'hF, 32'hFFFF_FFFF, RST_PRESET,  1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h7, 4'h3, 32'hAAAA_1234, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h4, 4'h0, 32'h0,        32'hFFFF_1234, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h8, 4'hF, 32'h1234_5678, 32'h0,       1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h8, 4'h0, 32'h0,        32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h4, 4'h0, 32'h0,        32'h0,        1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h4, 4'hF, 32'h0,        32'h0,        1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h4, 4'h0, 32'h0,        32'hFFFF_1234, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h0, 4'h1, 32'hFFFF_FFF4, 32'h0,       1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h0, 4'h0, 32'h0,        32'h4,        1'b0};
        vecs[14] = '{1'b1, 1'b1, 32'h0, 4'hE, 32'h0000_000F, 32'h4,       1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h0, 4'h0, 32'h0,        32'h4,        1'b0};
        vecs[16] = '{1'b1, 1'b1, 32'h0, 4'hF, 32'h0,        32'h4,        1'b0};
        vecs[17] = '{1'b1, 1'b0, 32'h0, 4'h0, 32'h0,        32'h0,        1'b0};

        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Register access vectors
        for (int i = 0; i < NV; i++) begin
            sel = vecs[i].sel; we = vecs[i].we; addr = vecs[i].addr;
            be = vecs[i].be; wd = vecs[i].wd;
            #1;
            check($sformatf("vec%0d_rd", i), rd, vecs[i].expRd);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].expIrq));
            tick();
        end
        sel = 1'b0; we = 1'b0;

        // One-shot, PRESET=5; COUNT writes during CNT must be ignored
        busWrite(32'h4, 4'hF, 32'd5);
        busWrite(32'h0, 4'hF, 32'h9);
        for (int k = 0; k < 10; k++) begin
            sel = 1'b1; addr = 32'h8; we = (k == 4); be = 4'hF; wd = 32'h0;
            #1;
            expCnt = (k >= 2 && k <= 6) ? 32'(7 - k) : 32'h0;
            expIrq = (k >= 8);
            check($sformatf("os_count_k%0d", k), rd, expCnt);
            check($sformatf("os_irq_k%0d", k), 32'(irq), 32'(expIrq));
            tick();
        end
        we = 1'b0; sel = 1'b0;
        readCheck("os_en_cleared", 32'h0, 32'h8);
        check("os_irq_held", 32'(irq), 32'h1);
        busWrite(32'h0, 4'hF, 32'h8);
        check("os_irq_clr", 32'(irq), 32'h0);
        readCheck("os_ctrl_after_clr", 32'h0, 32'h8);

        // PRESET=0: interrupt 4 edges after the enabling write edge
        busWrite(32'h4, 4'hF, 32'h0);
        busWrite(32'h0, 4'hF, 32'h9);
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("p0_irq_k%0d", k), 32'(irq), 32'(k >= 4));
            tick();
        end
        busWrite(32'h0, 4'hF, 32'h8);
        check("p0_irq_clr", 32'(irq), 32'h0);

        // Auto-reload, PRESET=2: period 4, pulse 2 cycles wide
        busWrite(32'h4, 4'hF, 32'd2);
        busWrite(32'h0, 4'hF, 32'hB);
        for (int k = 0; k < 21; k++) begin
            sel = 1'b1; addr = 32'h8;
            #1;
            if (k < 2) expCnt = 32'h0;
            else case ((k - 2) % 4)
                0:       expCnt = 32'd2;
                1:       expCnt = 32'd1;
                default: expCnt = 32'd0;
            endcase
            expIrq = (k >= 5) && (((k - 5) % 4) < 2);
            check($sformatf("ar_count_k%0d", k), rd, expCnt);
            check($sformatf("ar_irq_k%0d", k), 32'(irq), 32'(expIrq));
            tick();
        end
        sel = 1'b0;
        busWrite(32'h0, 4'hF, 32'h0);
        repeat (4) tick();
        check("ar_stop_irq", 32'(irq), 32'h0);

        // EN cleared in CNT holds COUNT
        busWrite(32'h4, 4'hF, 32'd10);
        busWrite(32'h0, 4'hF, 32'h1);
        repeat (3) tick();
        busWrite(32'h0, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            readCheck($sformatf("hold_count_%0d", k), 32'h8, 32'd8);
            tick();
        end

        // PRESET write during CNT leaves COUNT alone; then reset mid-count
        busWrite(32'h0, 4'hF, 32'h1);
        repeat (2) tick();
        busWrite(32'h4, 4'hF, 32'd3);
        readCheck("pw_count", 32'h8, 32'd9);
        readCheck("pw_preset", 32'h4, 32'd3);
        tick();
        readCheck("pw_count_next", 32'h8, 32'd8);
        repeat (5) tick();
        readCheck("rst_pre_count", 32'h8, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        readCheck("rst_count", 32'h8, 32'h0);
        readCheck("rst_ctrl", 32'h0, 32'h0);
        readCheck("rst_preset", 32'h4, RST_PRESET);
        check("rst_irq", 32'(irq), 32'h0);
        repeat (12) tick();
        readCheck("rst_idle_count", 32'h8, 32'h0);
        check("rst_idle_irq", 32'(irq), 32'h0);

`ifdef TIMER_IRQ_STATUS_EN
        busWrite(32'h4, 4'hF, 32'h0);
        busWrite(32'h0, 4'hF, 32'h9);
        repeat (5) tick();
        readCheck("st_pending", 32'hC, 32'h1);
        check("st_irq", 32'(irq), 32'h1);
        busWrite(32'hC, 4'h2, 32'h1);
        readCheck("st_no_be0", 32'hC, 32'h1);
        busWrite(32'hC, 4'h1, 32'h1);
        readCheck("st_cleared", 32'hC, 32'h0);
        check("st_irq_clr", 32'(irq), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
